// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Decoupling instruction queue between fetch and decode.
//               Accepts whole FETCH_WIDTH-wide fetch bundles (slot 0 oldest,
//               slot i PC = fetch_pc + 4*i), presents up to DEQ_WIDTH oldest
//               entries to decode in program order, and stalls fetch when a
//               full bundle no longer fits. A flush discards every entry.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous reset, active-low
//               fetch_valid  - fetch bundle valid
//               fetch_inst   - bundle instructions, slot i at [32*i +: 32]
//               fetch_pc     - PC of slot 0
//               fetch_stall  - hold fetch (from registered count only)
//               flush        - redirect: empty the queue
//               dec_valid    - dec_valid[i] set when entry head+i exists
//               dec_inst     - instruction at head+i, at [32*i +: 32]
//               dec_pc       - PC at head+i, at [INST_ADDR_WIDTH*i +: ...]
//               dec_take     - entries consumed by decode this cycle
//               occupancy    - current entry count
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int DEQ_WIDTH       = 2,
  parameter int DEPTH           = 8,
  parameter int INST_ADDR_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch_valid,
  input  logic [32*FETCH_WIDTH-1:0]            fetch_inst,
  input  logic [INST_ADDR_WIDTH-1:0]           fetch_pc,
  output logic                                 fetch_stall,
  input  logic                                 flush,
  output logic [DEQ_WIDTH-1:0]                 dec_valid,
  output logic [32*DEQ_WIDTH-1:0]              dec_inst,
  output logic [INST_ADDR_WIDTH*DEQ_WIDTH-1:0] dec_pc,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]       dec_take,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FW_CNT    = CNT_W'(FETCH_WIDTH);
  localparam logic [CNT_W-1:0] DW_CNT    = CNT_W'(DEQ_WIDTH);
  localparam logic [PTR_W-1:0] FW_PTR    = PTR_W'(FETCH_WIDTH);

  // Entry storage; not reset, only entries below count are ever observed.
  logic [31:0]                inst_ram_q [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_ram_q   [DEPTH];

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] take_req;
  logic [CNT_W-1:0] take_lim;
  logic [CNT_W-1:0] take_eff;

  // Stall looks only at the registered count: a same-cycle dequeue never
  // opens space for the bundle presented in that cycle.
  assign free_slots  = DEPTH_CNT - count_q;
  assign fetch_stall = free_slots < FW_CNT;
  assign enq         = fetch_valid && !fetch_stall && !flush;
  assign occupancy   = count_q;

  // take_eff = min(dec_take, count, DEQ_WIDTH); an empty queue yields 0.
  always_comb begin
    take_req = CNT_W'(dec_take);
    take_lim = (count_q < DW_CNT) ? count_q : DW_CNT;
    take_eff = (take_req < take_lim) ? take_req : take_lim;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(take_eff);
      if (enq) begin
        tail_d = tail_q + FW_PTR;
      end
      count_d = count_q + (enq ? FW_CNT : '0) - take_eff;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Bundle write: all slots land at tail..tail+FETCH_WIDTH-1, wrapping.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        inst_ram_q[tail_q + PTR_W'(i)] <= fetch_inst[32*i +: 32];
        pc_ram_q[tail_q + PTR_W'(i)]   <= fetch_pc + INST_ADDR_WIDTH'(4*i);
      end
    end
  end

  // Decode view straight off the registered head; empty slots read as zero.
  generate
    for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_dec
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx       = head_q + PTR_W'(g);
      assign dec_valid[g] = count_q > CNT_W'(g);
      assign dec_inst[32*g +: 32] =
        dec_valid[g] ? inst_ram_q[rd_idx] : 32'd0;
      assign dec_pc[INST_ADDR_WIDTH*g +: INST_ADDR_WIDTH] =
        dec_valid[g] ? pc_ram_q[rd_idx] : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue
//               (FETCH_WIDTH=2, DEQ_WIDTH=2, DEPTH=8, INST_ADDR_WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [63:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        flush;
  logic [1:0]  dec_valid;
  logic [63:0] dec_inst;
  logic [63:0] dec_pc;
  logic [1:0]  dec_take;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue #(
    .FETCH_WIDTH    (2),
    .DEQ_WIDTH      (2),
    .DEPTH          (8),
    .INST_ADDR_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .fetch_pc   (fetch_pc),
    .fetch_stall(fetch_stall),
    .flush      (flush),
    .dec_valid  (dec_valid),
    .dec_inst   (dec_inst),
    .dec_pc     (dec_pc),
    .dec_take   (dec_take),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word derived from its PC so order and identity are checkable.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [1:0] take, input logic fl);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_inst  = {inst_of(pc + 32'd4), inst_of(pc)};
    dec_take    = take;
    flush       = fl;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc0);
    check({tag, "_pc"},   dec_pc,   {pc0 + 32'd4, pc0});
    check({tag, "_inst"}, dec_inst, {inst_of(pc0 + 32'd4), inst_of(pc0)});
  endtask

  initial begin
    logic [31:0] head_pc;
    logic [31:0] next_pc;

    reset = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    repeat (2) tick();

    // Reset state.
    check("rst_occ",   occupancy,   64'd0);
    check("rst_valid", dec_valid,   64'd0);
    check("rst_stall", fetch_stall, 64'd0);
    check("rst_pc",    dec_pc,      64'd0);
    check("rst_inst",  dec_inst,    64'd0);

    @(negedge clk);
    reset = 1'b1;
    tick();

    // Take on empty queue is ignored.
    drive(1'b0, 32'h0, 2'd2, 1'b0);
    tick();
    check("empty_take_occ", occupancy, 64'd0);

    // 1: one bundle at 0x100.
    drive(1'b1, 32'h100, 2'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    check("t1_valid", dec_valid, 64'd3);
    check_head("t1", 32'h100);
    check("t1_occ", occupancy, 64'd2);

    // 2: fill to 8, extra bundle dropped, drain one at a time.
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(8*k), 2'd0, 1'b0);
      tick();
    end
    check("t2_full_occ",   occupancy,   64'd8);
    check("t2_full_stall", fetch_stall, 64'd1);
    drive(1'b1, 32'h120, 2'd0, 1'b0);
    tick();
    check("t2_drop_occ", occupancy, 64'd8);
    check_head("t2_drop", 32'h100);
    drive(1'b0, 32'h0, 2'd1, 1'b0);
    tick();
    check("t2_take1_occ",   occupancy,   64'd7);
    check("t2_take1_stall", fetch_stall, 64'd1);
    tick();
    check("t2_take2_occ",   occupancy,   64'd6);
    check("t2_take2_stall", fetch_stall, 64'd0);
    check_head("t2_take2", 32'h108);

    // 4: at occupancy 6, bundle + take 2, then bundle + take 3 (clamped).
    drive(1'b1, 32'h120, 2'd2, 1'b0);
    tick();
    check("t4a_occ",   occupancy,   64'd6);
    check("t4a_stall", fetch_stall, 64'd0);
    check_head("t4a", 32'h110);
    drive(1'b1, 32'h128, 2'd3, 1'b0);
    tick();
    check("t4b_occ",   occupancy,   64'd6);
    check("t4b_stall", fetch_stall, 64'd0);
    check_head("t4b", 32'h118);

    // 3: steady stream across several pointer wraps.
    head_pc = 32'h118;
    next_pc = 32'h130;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, next_pc, 2'd2, 1'b0);
      tick();
      next_pc = next_pc + 32'd8;
      head_pc = head_pc + 32'd8;
      check($sformatf("t3_occ%0d", k), occupancy, 64'd6);
      check_head($sformatf("t3_%0d", k), head_pc);
    end

    // 5: flush at occupancy 5 beats bundle and take.
    drive(1'b0, 32'h0, 2'd1, 1'b0);
    tick();
    check("t5_pre_occ", occupancy, 64'd5);
    drive(1'b1, 32'h300, 2'd2, 1'b1);
    tick();
    check("t5_flush_occ",   occupancy, 64'd0);
    check("t5_flush_valid", dec_valid, 64'd0);
    drive(1'b1, 32'h400, 2'd0, 1'b0);
    tick();
    check("t5_post_valid", dec_valid, 64'd3);
    check_head("t5_post", 32'h400);

    // 6: asynchronous reset at occupancy 5.
    drive(1'b1, 32'h408, 2'd0, 1'b0);
    tick();
    drive(1'b1, 32'h410, 2'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 2'd1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    check("t6_pre_occ", occupancy, 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_occ",   occupancy,   64'd0);
    check("t6_async_valid", dec_valid,   64'd0);
    check("t6_async_stall", fetch_stall, 64'd0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    drive(1'b1, 32'h500, 2'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    check("t6_resume_occ", occupancy, 64'd2);
    check_head("t6_resume", 32'h500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
